// File: rtl/reg_native_arb.sv
// Round-robin arbiter sharing one downstream reg_native slave port between N_REQ masters.
// Optional REG_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins), no rr_ptr.
module reg_native_arb #(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned ADDR_WIDTH   = 48,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned TMOUT_CYCLES = 255,
   parameter logic [31:0] TMOUT_DATA   = 32'hdead_1eaf
) (
   input  logic                        pclk,
   input  logic                        presetn,
   input  logic [N_REQ-1:0]            up_req_vld,
   input  logic [N_REQ-1:0]            up_wr_en,
   input  logic [N_REQ-1:0]            up_rd_en,
   input  logic [N_REQ*ADDR_WIDTH-1:0] up_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] up_wr_data,
   input  logic [N_REQ-1:0]            up_non_sec,
   input  logic [N_REQ-1:0]            up_abort,
   output logic [N_REQ-1:0]            up_ack_vld,
   output logic [N_REQ-1:0]            up_err,
   output logic [DATA_WIDTH-1:0]       up_rd_data,
   output logic                        dn_req_vld,
   output logic                        dn_wr_en,
   output logic                        dn_rd_en,
   output logic [ADDR_WIDTH-1:0]       dn_addr,
   output logic [DATA_WIDTH-1:0]       dn_wr_data,
   output logic                        dn_non_sec,
   input  logic                        dn_ack_vld,
   input  logic [DATA_WIDTH-1:0]       dn_rd_data,
   input  logic                        dn_err,
   output logic                        busy,
   output logic                        proto_err
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMR_W = 16;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMOUT_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] TMO_DATA = DATA_WIDTH'(TMOUT_DATA);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   slot_addr  [N_REQ];
   logic [DATA_WIDTH-1:0]   slot_wdata [N_REQ];
   logic [N_REQ-1:0]        slot_wr, slot_rd, slot_ns;
   logic [N_REQ-1:0]        pend, pend_nx, cap, dup, req_eff, grant_oh;
   logic [PTR_W-1:0]        owner, owner_nx, win_idx;
   logic                    win_vld;
   logic [TMR_W-1:0]        timer, timer_nx;
   logic [DATA_WIDTH-1:0]   rsp_data, rsp_data_nx;
   logic                    rsp_err, rsp_err_nx;
   logic                    owner_aborted, aborted_nx;
   logic                    dn_vld_nx, ack_nx;
   logic [N_REQ-1:0]        owner_oh_nx;
`ifndef REG_ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0]        rr_ptr, rr_ptr_nx;
`endif

   // Slot capture: a request on an empty (or same-cycle aborted) slot is latched.
   assign cap     = up_req_vld & (~pend | up_abort);
   assign dup     = up_req_vld & pend & ~up_abort;
   assign req_eff = pend & ~up_abort;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < N_REQ; i++) begin
            slot_addr[i]  <= '0;
            slot_wdata[i] <= '0;
         end
         slot_wr <= '0;
         slot_rd <= '0;
         slot_ns <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (cap[i]) begin
               slot_addr[i]  <= up_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               slot_wdata[i] <= up_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
               slot_wr[i]    <= up_wr_en[i];
               slot_rd[i]    <= up_rd_en[i];
               slot_ns[i]    <= up_non_sec[i];
            end
         end
      end
   end

   // Winner search and FSM next state.
   always_comb begin
      state_nx    = state;
      owner_nx    = owner;
      timer_nx    = timer;
      rsp_data_nx = rsp_data;
      rsp_err_nx  = rsp_err;
      aborted_nx  = owner_aborted;
      grant_oh    = '0;
      win_vld     = 1'b0;
      win_idx     = '0;
`ifndef REG_ARB_FIXED_PRIO_EN
      rr_ptr_nx   = rr_ptr;
`endif

      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned j;
`ifdef REG_ARB_FIXED_PRIO_EN
         j = k;
`else
         j = k + 32'(rr_ptr);
         if (j >= N_REQ) j = j - N_REQ;
`endif
         if (!win_vld && req_eff[PTR_W'(j)]) begin
            win_vld = 1'b1;
            win_idx = PTR_W'(j);
         end
      end

      case (state)
         S_IDLE: begin
            if (win_vld) begin
               owner_nx           = win_idx;
               grant_oh[win_idx]  = 1'b1;
               aborted_nx         = 1'b0;
               state_nx           = S_ISSUE;
`ifndef REG_ARB_FIXED_PRIO_EN
               rr_ptr_nx = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`endif
            end
         end
         S_ISSUE: begin
            timer_nx = '0;
            if (dn_ack_vld) begin
               rsp_data_nx = dn_rd_data;
               rsp_err_nx  = dn_err;
               state_nx    = S_RESP;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            timer_nx = timer + TMR_W'(1);
            if (dn_ack_vld) begin
               rsp_data_nx = dn_rd_data;
               rsp_err_nx  = dn_err;
               state_nx    = S_RESP;
            end else if (timer == TMR_LAST) begin
               rsp_data_nx = TMO_DATA;
               rsp_err_nx  = 1'b1;
               state_nx    = S_RESP;
            end
         end
         S_RESP: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      // The owner giving up only suppresses its ack; the downstream access still completes.
      if (state != S_IDLE && up_abort[owner]) aborted_nx = 1'b1;

      pend_nx     = (pend & ~up_abort & ~grant_oh) | cap;
      dn_vld_nx   = (state_nx == S_ISSUE);
      ack_nx      = (state_nx == S_RESP) && !aborted_nx;
      owner_oh_nx = N_REQ'(1) << owner_nx;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state         <= S_IDLE;
         pend          <= '0;
         owner         <= '0;
         timer         <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         owner_aborted <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
         rr_ptr        <= '0;
`endif
      end else begin
         state         <= state_nx;
         pend          <= pend_nx;
         owner         <= owner_nx;
         timer         <= timer_nx;
         rsp_data      <= rsp_data_nx;
         rsp_err       <= rsp_err_nx;
         owner_aborted <= aborted_nx;
`ifndef REG_ARB_FIXED_PRIO_EN
         rr_ptr        <= rr_ptr_nx;
`endif
      end
   end

   // Registered outputs, decoded from the next state.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         dn_req_vld <= 1'b0;
         dn_wr_en   <= 1'b0;
         dn_rd_en   <= 1'b0;
         dn_non_sec <= 1'b0;
         dn_addr    <= '0;
         dn_wr_data <= '0;
         up_ack_vld <= '0;
         up_err     <= '0;
         up_rd_data <= '0;
         busy       <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         dn_req_vld <= dn_vld_nx;
         dn_wr_en   <= dn_vld_nx & slot_wr[owner_nx];
         dn_rd_en   <= dn_vld_nx & slot_rd[owner_nx];
         dn_non_sec <= dn_vld_nx & slot_ns[owner_nx];
         dn_addr    <= dn_vld_nx ? slot_addr[owner_nx] : '0;
         dn_wr_data <= dn_vld_nx ? slot_wdata[owner_nx] : '0;
         up_ack_vld <= ack_nx ? owner_oh_nx : '0;
         up_err     <= (ack_nx && rsp_err_nx) ? owner_oh_nx : '0;
         up_rd_data <= ack_nx ? rsp_data_nx : '0;
         busy       <= (state_nx != S_IDLE) || (|pend_nx);
         proto_err  <= proto_err | (|dup);
      end
   end

endmodule

// File: tb/tb_reg_native_arb.sv
// Directed table-driven bench for reg_native_arb (N_REQ=2, TMOUT_CYCLES=4, round-robin build).
module tb_reg_native_arb;

   localparam int unsigned N   = 2;
   localparam int unsigned AW  = 48;
   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 4 + AW + DW + 2 + 2 + DW + 2;

   logic            pclk = 1'b0;
   logic            presetn;
   logic [N-1:0]    up_req_vld, up_wr_en, up_rd_en, up_non_sec, up_abort;
   logic [N*AW-1:0] up_addr;
   logic [N*DW-1:0] up_wr_data;
   logic [N-1:0]    up_ack_vld, up_err;
   logic [DW-1:0]   up_rd_data;
   logic            dn_req_vld, dn_wr_en, dn_rd_en, dn_non_sec;
   logic [AW-1:0]   dn_addr;
   logic [DW-1:0]   dn_wr_data;
   logic            dn_ack_vld, dn_err;
   logic [DW-1:0]   dn_rd_data;
   logic            busy, proto_err;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   reg_native_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TMOUT_CYCLES(4),
                    .TMOUT_DATA(32'hdead_1eaf)) dut (
      .pclk(pclk), .presetn(presetn),
      .up_req_vld(up_req_vld), .up_wr_en(up_wr_en), .up_rd_en(up_rd_en),
      .up_addr(up_addr), .up_wr_data(up_wr_data), .up_non_sec(up_non_sec),
      .up_abort(up_abort), .up_ack_vld(up_ack_vld), .up_err(up_err),
      .up_rd_data(up_rd_data), .dn_req_vld(dn_req_vld), .dn_wr_en(dn_wr_en),
      .dn_rd_en(dn_rd_en), .dn_addr(dn_addr), .dn_wr_data(dn_wr_data),
      .dn_non_sec(dn_non_sec), .dn_ack_vld(dn_ack_vld), .dn_rd_data(dn_rd_data),
      .dn_err(dn_err), .busy(busy), .proto_err(proto_err)
   );

   typedef struct {
      logic [1:0]  req, wr, rd, ab;
      logic [15:0] a0;
      logic        dack;
      logic [31:0] ddat;
      logic        derr;
      logic [3:0]  x_dq;     // {dn_req_vld, dn_wr_en, dn_rd_en, dn_non_sec}
      logic [15:0] x_addr;
      logic [31:0] x_wd;
      logic [1:0]  x_ack, x_err;
      logic [31:0] x_rdat;
      logic        x_busy, x_perr;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(logic [1:0] req, logic [1:0] wr, logic [1:0] rd, logic [1:0] ab,
                               logic [15:0] a0, logic dack, logic [31:0] ddat, logic derr,
                               logic [3:0] x_dq, logic [15:0] x_addr, logic [31:0] x_wd,
                               logic [1:0] x_ack, logic [1:0] x_err, logic [31:0] x_rdat,
                               logic x_busy, logic x_perr);
      vec_t v;
      v.req = req; v.wr = wr; v.rd = rd; v.ab = ab; v.a0 = a0;
      v.dack = dack; v.ddat = ddat; v.derr = derr;
      v.x_dq = x_dq; v.x_addr = x_addr; v.x_wd = x_wd; v.x_ack = x_ack;
      v.x_err = x_err; v.x_rdat = x_rdat; v.x_busy = x_busy; v.x_perr = x_perr;
      return v;
   endfunction

   function automatic logic [CW-1:0] actual_bus();
      return {dn_req_vld, dn_wr_en, dn_rd_en, dn_non_sec, dn_addr, dn_wr_data,
              up_ack_vld, up_err, up_rd_data, busy, proto_err};
   endfunction

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      up_req_vld = '0; up_wr_en = '0; up_rd_en = '0; up_abort = '0;
      dn_ack_vld = 1'b0; dn_rd_data = '0; dn_err = 1'b0;
   endtask

   initial begin
      logic [CW-1:0] zero_bus;
      int lat;
      bit seen;
      zero_bus = '0;
      presetn = 1'b0;
      drive_idle();
      up_non_sec = 2'b10;
      up_addr    = {48'h200, 48'h0};
      up_wr_data = {32'h0000_bbbb, 32'h0000_aaaa};

      // Simultaneous requests + single read latency, round-robin repeat with timeout
      tbl.push_back(mk(2'b11, 2'b10, 2'b01, 2'b00, 16'h100, 0, 0, 0, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 16'h100, 32'haaaa, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 4'b0000, 0, 0, 2'b01, 2'b00, 32'h1234_5678, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 16'h200, 32'hbbbb, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hcafe_0001, 1, 4'b0000, 0, 0, 2'b10, 2'b10, 32'hcafe_0001, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b11, 2'b00, 16'h104, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 16'h104, 32'haaaa, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1111_0000, 0, 4'b0000, 0, 0, 2'b01, 2'b00, 32'h1111_0000, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 16'h200, 32'hbbbb, 0, 0, 0, 1, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b10, 2'b10, 32'hdead_1eaf, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
      // Abort of owner 1 in WAIT while requester 0 is pending
      tbl.push_back(mk(2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 16'h200, 32'hbbbb, 0, 0, 0, 1, 0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 16'h108, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 16'h108, 32'haaaa, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h42, 0, 4'b0000, 0, 0, 2'b01, 2'b00, 32'h42, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
      // Duplicate request on a pending slot
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 16'h10c, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 16'h1f0, 0, 0, 0, 4'b1010, 16'h10c, 32'haaaa, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h77, 0, 4'b0000, 0, 0, 2'b01, 2'b00, 32'h77, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));

      repeat (3) @(posedge pclk);
      #1 chk("reset_state", actual_bus(), zero_bus);
      @(negedge pclk) presetn = 1'b1;

      foreach (tbl[i]) begin
         @(negedge pclk);
         up_req_vld = tbl[i].req;
         up_wr_en   = tbl[i].wr;
         up_rd_en   = tbl[i].rd;
         up_abort   = tbl[i].ab;
         up_addr    = {48'h200, 48'(tbl[i].a0)};
         dn_ack_vld = tbl[i].dack;
         dn_rd_data = tbl[i].ddat;
         dn_err     = tbl[i].derr;
         @(posedge pclk);
         #1 chk($sformatf("vec%0d", i), actual_bus(),
                {tbl[i].x_dq, 48'(tbl[i].x_addr), tbl[i].x_wd, tbl[i].x_ack, tbl[i].x_err,
                 tbl[i].x_rdat, tbl[i].x_busy, tbl[i].x_perr});
      end

      // Latency with a bounded wait, then reset while waiting on downstream
      @(negedge pclk);
      up_req_vld = 2'b01; up_rd_en = 2'b01; up_addr = {48'h200, 48'h120};
      dn_ack_vld = 1'b0; up_abort = '0; up_wr_en = '0;
      lat = 0; seen = 1'b0;
      for (int c = 1; c <= 8 && !seen; c++) begin
         @(posedge pclk);
         #1;
         if (c == 1) drive_idle();
         if (dn_req_vld) begin
            seen = 1'b1;
            lat = c;
         end
      end
      chk1("req_to_dn_latency", 32'(lat), 32'd2);
      chk1("dn_addr_late", dn_addr[31:0], 32'h120);
      @(posedge pclk);
      #1 chk1("in_wait_busy", {30'd0, busy, dn_req_vld}, 32'b10);
      @(negedge pclk) presetn = 1'b0;
      #1 chk("async_reset_outputs", actual_bus(), zero_bus);
      @(negedge pclk);
      presetn = 1'b1;
      dn_ack_vld = 1'b1; dn_rd_data = 32'h99; dn_err = 1'b1;
      @(posedge pclk);
      #1 chk("ack_after_reset_ignored", actual_bus(), zero_bus);
      @(negedge pclk) drive_idle();
      repeat (2) @(posedge pclk);
      #1 chk("idle_after_reset", actual_bus(), zero_bus);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
